// File: rtl/dffram_nr1w.sv
// Flip-flop RAM with one lane-masked write port and NREAD independent read ports.
// Each read port can be registered or not; writes can pass straight through, and a built-in sweep clears the array.
module dffram_nr1w #(
   parameter int                DWIDTH        = 8,
   parameter int                DEPTH         = 28,
   parameter int                AWIDTH        = 5,
   parameter int                NREAD         = 2,
   parameter int                LANES         = 2,
   parameter logic [DWIDTH-1:0] INIT_VALUE    = '0,
   parameter bit                INIT_ON_RESET = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_req,
   output logic                    busy,
   input  logic                    w_en,
   input  logic [AWIDTH-1:0]       w_addr,
   input  logic [LANES-1:0]        w_lane,
   input  logic [DWIDTH-1:0]       w_data,
   output logic                    w_drop,
   input  logic [NREAD*AWIDTH-1:0] r_addr,
   output logic [NREAD*DWIDTH-1:0] r_data,
   input  logic [NREAD-1:0]        cfg_rdbuf,
   input  logic                    cfg_wt
);

   localparam int                LW      = DWIDTH / LANES;
   localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH-1:0] LAST_A  = AWIDTH'(DEPTH - 1);

   typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

   state_t              state_q, state_d;
   logic [AWIDTH-1:0]   cnt_q, cnt_d;
   logic                drop_q, drop_d;
   logic [DWIDTH-1:0]   mem_q [DEPTH];
   logic [DWIDTH-1:0]   buf_q [NREAD];
   logic [DWIDTH-1:0]   cur   [NREAD];
   logic [DWIDTH-1:0]   wmask;
   logic [DWIDTH-1:0]   wmerge;
   logic [AWIDTH-1:0]   ra;
   logic                w_in_range;
   logic                w_acc;

   assign busy       = (state_q == ST_SWEEP);
   assign w_drop     = drop_q;
   assign w_in_range = ({1'b0, w_addr} < DEPTH_W);
   assign w_acc      = w_en && !busy && w_in_range && (w_lane != '0);

   always_comb begin
      wmask = '0;
      for (int l = 0; l < LANES; l++) begin
         wmask[l*LW +: LW] = {LW{w_lane[l]}};
      end
   end

   // The merged word serves both the array update and the write-through path.
   assign wmerge = (mem_q[w_addr] & ~wmask) | (w_data & wmask);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drop_d  = w_en && (w_lane != '0) && (busy || !w_in_range);
      case (state_q)
         ST_IDLE: begin
            if (init_req) begin
               state_d = ST_SWEEP;
               cnt_d   = '0;
            end
         end
         ST_SWEEP: begin
            if (cnt_q == LAST_A) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT_ON_RESET ? ST_SWEEP : ST_IDLE;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   // The storage array has no reset; it holds undefined data until it is swept or written.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem_q[cnt_q] <= INIT_VALUE;
      end else if (w_acc) begin
         mem_q[w_addr] <= wmerge;
      end
   end

   always_comb begin
      ra     = '0;
      r_data = '0;
      cur    = '{default: '0};
      for (int p = 0; p < NREAD; p++) begin
         ra = r_addr[p*AWIDTH +: AWIDTH];
         if (busy) begin
            cur[p] = INIT_VALUE;
         end else if ({1'b0, ra} >= DEPTH_W) begin
            cur[p] = '0;
         end else if (cfg_wt && w_acc && (ra == w_addr)) begin
            cur[p] = wmerge;
         end else begin
            cur[p] = mem_q[ra];
         end
         r_data[p*DWIDTH +: DWIDTH] = cfg_rdbuf[p] ? buf_q[p] : cur[p];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NREAD; p++) buf_q[p] <= '0;
      end else begin
         for (int p = 0; p < NREAD; p++) buf_q[p] <= cur[p];
      end
   end

endmodule

// File: tb/tb_dffram_nr1w.sv
// Testbench for dffram_nr1w: directed scenarios plus randomized traffic.
// Every cycle is checked against an array-based reference model.
module tb_dffram_nr1w;

   localparam int         DW = 8;
   localparam int         DP = 28;
   localparam int         AW = 5;
   localparam int         NR = 2;
   localparam int         LN = 2;
   localparam logic [7:0] IV = 8'hA5;

   logic           clk       = 1'b0;
   logic           rst       = 1'b1;
   logic           init_req  = 1'b0;
   logic           busy;
   logic           w_en      = 1'b0;
   logic [AW-1:0]  w_addr    = '0;
   logic [LN-1:0]  w_lane    = '0;
   logic [DW-1:0]  w_data    = '0;
   logic           w_drop;
   logic [NR*AW-1:0] r_addr  = '0;
   logic [NR*DW-1:0] r_data;
   logic [NR-1:0]  cfg_rdbuf = '0;
   logic           cfg_wt    = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem_m [DP];
   logic [7:0] buf_m [NR];
   bit         sweep_m;
   int         ptr_m;
   bit         drop_m;

   always #5 clk = ~clk;

   dffram_nr1w #(
      .DWIDTH(DW), .DEPTH(DP), .AWIDTH(AW), .NREAD(NR), .LANES(LN),
      .INIT_VALUE(IV), .INIT_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .init_req(init_req), .busy(busy),
      .w_en(w_en), .w_addr(w_addr), .w_lane(w_lane), .w_data(w_data),
      .w_drop(w_drop), .r_addr(r_addr), .r_data(r_data),
      .cfg_rdbuf(cfg_rdbuf), .cfg_wt(cfg_wt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rd(input int p);
      return r_data[p*DW +: DW];
   endfunction

   function automatic logic [7:0] lanemask(input logic [1:0] ln);
      return {{4{ln[1]}}, {4{ln[0]}}};
   endfunction

   function automatic bit acc_m();
      return w_en && !sweep_m && (int'(w_addr) < DP) && (w_lane != 2'b00);
   endfunction

   function automatic logic [7:0] cur_m(input int p);
      int         a = int'(r_addr[p*AW +: AW]);
      logic [7:0] m = lanemask(w_lane);
      if (sweep_m) return IV;
      if (a >= DP) return 8'h00;
      if (cfg_wt && acc_m() && a == int'(w_addr)) return (mem_m[a] & ~m) | (w_data & m);
      return mem_m[a];
   endfunction

   task automatic model_reset();
      sweep_m = 1'b1;
      ptr_m   = 0;
      drop_m  = 1'b0;
      for (int p = 0; p < NR; p++) buf_m[p] = 8'h00;
   endtask

   // One clock: compare all outputs mid-cycle, then advance the model at the edge.
   task automatic step();
      logic [7:0] c [NR];
      @(negedge clk);
      chk("busy", 32'(busy), 32'(sweep_m));
      chk("w_drop", 32'(w_drop), 32'(drop_m));
      for (int p = 0; p < NR; p++) begin
         c[p] = cur_m(p);
         chk($sformatf("rdata%0d", p), 32'(rd(p)), 32'(cfg_rdbuf[p] ? buf_m[p] : c[p]));
      end
      @(posedge clk);
      drop_m = w_en && (w_lane != 2'b00) && (sweep_m || int'(w_addr) >= DP);
      if (sweep_m) mem_m[ptr_m] = IV;
      else if (acc_m())
         mem_m[w_addr] = (mem_m[w_addr] & ~lanemask(w_lane)) | (w_data & lanemask(w_lane));
      if (sweep_m) begin
         if (ptr_m == DP - 1) sweep_m = 1'b0;
         else ptr_m++;
      end else if (init_req) begin
         sweep_m = 1'b1;
         ptr_m   = 0;
      end
      for (int p = 0; p < NR; p++) buf_m[p] = c[p];
      #1;
   endtask

   task automatic count_busy(input string tag, input int exp);
      int n = 0;
      while (busy && n < 60) begin
         step();
         n++;
      end
      chk(tag, 32'(n), 32'(exp));
   endtask

   initial begin
      for (int i = 0; i < DP; i++) mem_m[i] = 8'h00;
      model_reset();
      cfg_rdbuf = 2'b11;
      #12;
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_drop", 32'(w_drop), 32'd0);
      chk("rst_buf", 32'(r_data), 32'd0);
      #5 rst = 1'b0;
      model_reset();
      count_busy("sweep_len", 28);

      cfg_rdbuf = 2'b00;
      for (int a = 0; a < DP; a++) begin
         r_addr = {5'(a), 5'(a)};
         #1;
         chk("swept_p0", 32'(rd(0)), 32'(IV));
         chk("swept_p1", 32'(rd(1)), 32'(IV));
         step();
      end

      // Lane merge; port 0 buffered, port 1 unbuffered
      w_en = 1'b1; w_addr = 5'd3; w_data = 8'h3C; w_lane = 2'b11;
      r_addr = {5'd3, 5'd3}; cfg_rdbuf = 2'b01; cfg_wt = 1'b0;
      step();
      w_data = 8'hF0; w_lane = 2'b10;
      step();
      w_en = 1'b0;
      #1;
      chk("lane_unbuf", 32'(rd(1)), 32'h FC);
      chk("lane_buf_old", 32'(rd(0)), 32'h3C);
      step();
      chk("lane_buf_new", 32'(rd(0)), 32'hFC);

      // Write-through versus read-during-write
      w_en = 1'b1; w_addr = 5'd7; w_data = 8'h00; w_lane = 2'b11;
      r_addr = {5'd7, 5'd7}; cfg_rdbuf = 2'b00; cfg_wt = 1'b0;
      step();
      w_data = 8'h55; cfg_wt = 1'b1;
      #1;
      chk("wt_p0", 32'(rd(0)), 32'h55);
      chk("wt_p1", 32'(rd(1)), 32'h55);
      step();
      w_data = 8'h00; cfg_wt = 1'b0;
      step();
      w_data = 8'h55;
      #1;
      chk("nowt_same", 32'(rd(0)), 32'h00);
      step();
      w_en = 1'b0;
      #1;
      chk("nowt_after", 32'(rd(0)), 32'h55);

      // Out-of-range write and read
      w_en = 1'b1; w_addr = 5'd30; w_data = 8'hFF; w_lane = 2'b11;
      step();
      w_en = 1'b0; r_addr = {5'd0, 5'd30};
      #1;
      chk("oor_drop", 32'(w_drop), 32'd1);
      chk("oor_read", 32'(rd(0)), 32'h00);
      chk("oor_addr0", 32'(rd(1)), 32'(IV));
      step();
      chk("oor_drop_end", 32'(w_drop), 32'd0);

      // Sweep request accompanied by a write, then a write during the sweep
      init_req = 1'b1; w_en = 1'b1; w_addr = 5'd27; w_data = 8'h11; w_lane = 2'b11;
      step();
      init_req = 1'b0; w_addr = 5'd5; w_data = 8'h77; r_addr = {5'd27, 5'd27};
      #1;
      chk("swp_busy", 32'(busy), 32'd1);
      chk("swp_read", 32'(rd(0)), 32'(IV));
      step();
      w_en = 1'b0;
      chk("swp_drop", 32'(w_drop), 32'd1);
      count_busy("swp_len", 27);
      r_addr = {5'd5, 5'd27};
      #1;
      chk("swp_a27", 32'(rd(0)), 32'(IV));
      chk("swp_a5", 32'(rd(1)), 32'(IV));

      // Reset in the middle of a sweep
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      repeat (10) step();
      #2 rst = 1'b1;
      cfg_rdbuf = 2'b01;
      #1;
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_drop", 32'(w_drop), 32'd0);
      chk("mid_buf", 32'(rd(0)), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
      count_busy("mid_restart_len", 28);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         w_en      = ($urandom_range(0, 3) != 0);
         w_addr    = 5'($urandom_range(0, 31));
         w_lane    = 2'($urandom_range(0, 3));
         w_data    = 8'($urandom);
         r_addr[4:0] = $urandom_range(0, 1) ? w_addr : 5'($urandom_range(0, 31));
         r_addr[9:5] = $urandom_range(0, 1) ? w_addr : 5'($urandom_range(0, 31));
         cfg_rdbuf = 2'($urandom);
         cfg_wt    = 1'($urandom);
         init_req  = ($urandom_range(0, 49) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
